// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared constants for the multiply/divide unit.
//   - HILO op codes (4 bits) as produced by the decode controller
//   - FSM state encoding and the packed FSM register layout
//   - default busy-cycle counts for multiply and divide
//   - is_multi_op(): which op codes start a multi-cycle operation
// Optional feature macro: MDU_MADD_EN (codes 9..12 become madd/maddu/msub/msubu;
// without it those codes decode as none).
package mdu_ctrl_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;
  localparam logic [3:0] MDU_MADD  = 4'd9;
  localparam logic [3:0] MDU_MADDU = 4'd10;
  localparam logic [3:0] MDU_MSUB  = 4'd11;
  localparam logic [3:0] MDU_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // Whole FSM state in one packed register so checkers can bind to it.
  typedef struct packed {
    mdu_state_e state;
    logic [3:0] count;
  } mdu_fsm_t;

  function automatic logic is_multi_op(input logic [3:0] op);
    logic r;
    case (op)
      MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational arithmetic for the MDU.
// Ports:
//   op      in  4   HILO op code
//   rs, rt  in  32  operands
//   hi, lo  in  32  current HI/LO (accumulate base for madd/msub)
//   res     out 64  {hi,lo} result to be committed
//   we      out 1   result may be written (0 for divide by zero / non-arith ops)
// Optional feature macro: MDU_MADD_EN adds the accumulate datapath.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        we
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
  // as quotient 0x80000000, remainder 0.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign div_signed = (op == MDU_DIV);
  assign a_neg  = div_signed & rs[31];
  assign b_neg  = div_signed & rt[31];
  assign a_mag  = a_neg ? (~rs + 32'd1) : rs;
  assign b_mag  = b_neg ? (~rt + 32'd1) : rt;
  // Keep the divider free of X when dividing by zero; we=0 blocks the result.
  assign b_safe = (rt == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

`ifndef MDU_MADD_EN
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    res = 64'd0;
    we  = 1'b0;
    case (op)
      MDU_MULT:  begin res = prod_s; we = 1'b1; end
      MDU_MULTU: begin res = prod_u; we = 1'b1; end
      MDU_DIV, MDU_DIVU: begin
        res = {rem, quot};
        we  = (rt != 32'd0);
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  begin res = {hi, lo} + prod_s; we = 1'b1; end
      MDU_MADDU: begin res = {hi, lo} + prod_u; we = 1'b1; end
      MDU_MSUB:  begin res = {hi, lo} - prod_s; we = 1'b1; end
      MDU_MSUBU: begin res = {hi, lo} - prod_u; we = 1'b1; end
`endif
      default: begin res = 64'd0; we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit for the E stage; owns HI/LO.
// Ports:
//   clk        in  1   core clock, rising edge
//   reset      in  1   asynchronous active-low reset
//   op         in  4   HILO op code of the E-stage instruction
//   start      in  1   E-stage instruction is a multi-cycle MDU op
//   rs_val     in  32  forwarded rs operand
//   rt_val     in  32  forwarded rt operand
//   d_use_mdu  in  1   D-stage instruction uses the MDU
//   busy       out 1   multi-cycle operation in progress
//   stall      out 1   stall request to the hazard unit
//   mdu_out    out 32  HI (mfhi) or LO (mflo), else 0
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, MULT_CYCLES latency).
//
// Handshake: start is a single-cycle request, accepted only in IDLE. If start
// is sampled in cycle T, busy is high for cycles T+1..T+N and the new HI/LO
// are visible from T+N+1. start or mthi/mtlo seen while busy are ignored; the
// hazard unit uses stall to keep such instructions out of E.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_use_mdu,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_fsm_t    fsm;
  logic [63:0] pend_res;
  logic        pend_we;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] calc_res;
  logic        calc_we;
  logic        is_div;

  mdu_calc u_calc (
    .op  (op),
    .rs  (rs_val),
    .rt  (rt_val),
    .hi  (hi),
    .lo  (lo),
    .res (calc_res),
    .we  (calc_we)
  );

  assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm      <= '{state: IDLE, count: 4'd0};
      pend_res <= 64'd0;
      pend_we  <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      case (fsm.state)
        IDLE: begin
          if (start && is_multi_op(op)) begin
            // The result is computed at issue; the counter only models latency.
            pend_res  <= calc_res;
            pend_we   <= calc_we;
            fsm.count <= is_div ? DIV_N : MULT_N;
            fsm.state <= BUSY;
          end else if (op == MDU_MTHI) begin
            hi <= rs_val;
          end else if (op == MDU_MTLO) begin
            lo <= rs_val;
          end
        end
        BUSY: begin
          if (fsm.count == 4'd1) begin
            if (pend_we) begin
              hi <= pend_res[63:32];
              lo <= pend_res[31:0];
            end
            pend_we   <= 1'b0;
            fsm.count <= 4'd0;
            fsm.state <= IDLE;
          end else begin
            fsm.count <= fsm.count - 4'd1;
          end
        end
        default: fsm.state <= IDLE;
      endcase
    end
  end

  assign busy  = (fsm.state == BUSY);
  assign stall = d_use_mdu & (start | busy);

  always_comb begin
    mdu_out = 32'd0;
    if (op == MDU_MFHI)      mdu_out = hi;
    else if (op == MDU_MFLO) mdu_out = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed, table-driven bench for mdu_ctrl plus hand-written
// sequences for stall, reset-during-busy and undefined op codes.
module tb_mdu_ctrl;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  op = OP_NONE;
  logic        start = 1'b0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_use_mdu = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] mdu_out;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .start     (start),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_use_mdu (d_use_mdu),
    .busy      (busy),
    .stall     (stall),
    .mdu_out   (mdu_out)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string nm, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic expect_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    check32(nm, act);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    op = OP_MTHI; rs_val = h; tick();
    op = OP_MTLO; rs_val = l; tick();
    op = OP_NONE; rs_val = 32'd0;
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    op = OP_MFHI; #1;
    expect_val({nm, "_hi"}, mdu_out, eh);
    op = OP_MFLO; #1;
    expect_val({nm, "_lo"}, mdu_out, el);
    op = OP_NONE; #1;
  endtask

  // Issues one start and counts busy cycles; returns in the first idle cycle.
  task automatic run_multi(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, output int n);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    tick();
    start = 1'b0; op = OP_NONE; rs_val = 32'd0; rt_val = 32'd0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_n;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sc;
    int bc;

    vecs[0] = '{"mult_neg1x2",  OP_MULT,  32'hFFFFFFFF, 32'd2,        32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu_max2",   OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h11, 32'h22, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"div_m7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        32'h11, 32'h22, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_by0",     OP_DIVU,  32'd5,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
    vecs[4] = '{"div_ovf",      OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h11, 32'h22, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"div_7_m2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h11, 32'h22, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{"divu_100_7",   OP_DIVU,  32'd100,      32'd7,        32'h11, 32'h22, 32'h00000002, 32'h0000000E, 10};
    vecs[7] = '{"mult_min_min", OP_MULT,  32'h80000000, 32'h80000000, 32'h11, 32'h22, 32'h40000000, 32'h00000000, 5};
    vecs[8] = '{"multu_max_sq", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11, 32'h22, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9] = '{"div_by0",      OP_DIV,   32'd0,        32'd0,        32'h33, 32'h44, 32'h00000033, 32'h00000044, 10};

    // reset
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_val("rst_busy", {31'd0, busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    expect_val("idle_out_none", mdu_out, 32'd0);

    // table
    for (int i = 0; i < 10; i++) begin
      write_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
      run_multi(vecs[i].op, vecs[i].rs, vecs[i].rt, n);
      expect_val({vecs[i].name, "_busy_n"}, n, vecs[i].exp_n);
      read_hilo(vecs[i].name, vecs[i].exp_hi, vecs[i].exp_lo);
    end

    // stall held over start and busy: 1 start cycle + 5 busy cycles
    d_use_mdu = 1'b1;
    #1;
    expect_val("stall_idle", {31'd0, stall}, 32'd0);
    sc = 0;
    op = OP_MULT; rs_val = 32'h00010000; rt_val = 32'h00030000; start = 1'b1;
    #1;
    if (stall) sc++;
    tick();
    start = 1'b0; op = OP_NONE; rs_val = 32'd0; rt_val = 32'd0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (stall) sc++;
      tick();
    end
    expect_val("stall_cycles", sc, 32'd6);
    d_use_mdu = 1'b0;
    read_hilo("stall_mult", 32'h00000003, 32'h00000000);

    // no stall request when D does not use the MDU
    sc = 0;
    op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7; start = 1'b1;
    #1;
    if (stall) sc++;
    tick();
    start = 1'b0; op = OP_NONE;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (stall) sc++;
      tick();
    end
    expect_val("nostall_cycles", sc, 32'd0);
    read_hilo("nostall_mult", 32'd0, 32'd42);

    // reset during busy cycle 3 discards the pending result
    write_hilo(32'hAA, 32'hBB);
    op = OP_MULT; rs_val = 32'hFFFFFFFF; rt_val = 32'd2; start = 1'b1;
    tick();
    start = 1'b0; op = OP_NONE;
    tick();
    tick();
    reset = 1'b0;
    #1;
    expect_val("midrst_busy", {31'd0, busy}, 32'd0);
    read_hilo("midrst", 32'd0, 32'd0);
    tick();
    reset = 1'b1;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy) bc++;
      tick();
    end
    expect_val("midrst_late_busy", bc, 32'd0);
    read_hilo("midrst_after", 32'd0, 32'd0);

    // undefined op with start behaves as none
    write_hilo(32'h55, 32'h66);
    op = 4'd13; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    tick();
    start = 1'b0; op = OP_NONE;
    expect_val("undef13_busy", {31'd0, busy}, 32'd0);
    read_hilo("undef13", 32'h55, 32'h66);

`ifdef MDU_MADD_EN
    write_hilo(32'd0, 32'd5);
    run_multi(4'd9, 32'd3, 32'd4, n);
    expect_val("madd_busy_n", n, 32'd5);
    read_hilo("madd", 32'd0, 32'd17);
`else
    run_multi(4'd9, 32'd3, 32'd4, n);
    expect_val("op9_busy_n", n, 32'd0);
    read_hilo("op9", 32'h55, 32'h66);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
